// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - frame-level round-robin arbiter sharing one UART transmitter between two byte requesters
// Optional owner-stall timeout in HOLD is built when UART_ARB_TIMEOUT_EN is defined.
module uart_tx_arbiter #(
  parameter int DATA_W     = 8,
  parameter int GAP_CYCLES = 16,
  parameter int TIMEOUT    = 2000000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rq_valid_0,
  input  logic [DATA_W-1:0] rq_data_0,
  input  logic              rq_last_0,
  output logic              rq_ready_0,
  input  logic              rq_valid_1,
  input  logic [DATA_W-1:0] rq_data_1,
  input  logic              rq_last_1,
  output logic              rq_ready_1,
  output logic              tx_start,
  output logic [DATA_W-1:0] tx_data,
  input  logic              tx_done,
  output logic [1:0]        grant,
  output logic              busy,
  output logic              abort
);

  typedef enum logic [2:0] {IDLE, SEND, WAIT, HOLD, GAP} state_t;

  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  state_t            state_q, state_d;
  logic              owner_q, owner_d;
  logic              last_srv_q, last_srv_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              last_q, last_d;
  logic              tx_start_q, tx_start_d;
  logic [GAP_W-1:0]  gap_q, gap_d;
  logic [1:0]        ready_c;
  logic [1:0]        grant_c;
  logic              win;
  logic              sel_valid;
  logic              sel_port;
  logic              frame_end;

`ifdef UART_ARB_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
  logic             abort_q, abort_d;
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT;
`endif

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    last_srv_d = last_srv_q;
    data_d     = data_q;
    last_d     = last_q;
    gap_d      = gap_q;
    tx_start_d = 1'b0;
    ready_c    = 2'b00;
    frame_end  = 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
    hold_cnt_d = hold_cnt_q;
    abort_d    = 1'b0;
`endif
    // A tie goes to the port that was not served last; in HOLD only the owner may load.
    win       = (rq_valid_0 && rq_valid_1) ? ~last_srv_q : rq_valid_1;
    sel_valid = (state_q == IDLE) ? (rq_valid_0 || rq_valid_1)
                                  : (owner_q ? rq_valid_1 : rq_valid_0);
    sel_port  = (state_q == IDLE) ? win : owner_q;
    case (state_q)
      IDLE, HOLD: begin
        if (sel_valid) begin
          ready_c[sel_port] = 1'b1;
          owner_d           = sel_port;
          data_d            = sel_port ? rq_data_1 : rq_data_0;
          last_d            = sel_port ? rq_last_1 : rq_last_0;
          tx_start_d        = 1'b1;
          state_d           = SEND;
        end
`ifdef UART_ARB_TIMEOUT_EN
        else if (state_q == HOLD) begin
          if (hold_cnt_q == CNT_W'(TIMEOUT - 1)) begin
            abort_d   = 1'b1;
            frame_end = 1'b1;
          end else begin
            hold_cnt_d = hold_cnt_q + CNT_W'(1);
          end
        end
`endif
      end
      SEND: state_d = WAIT;
      WAIT: begin
        if (tx_done) begin
          if (last_q) begin
            frame_end = 1'b1;
          end else begin
            state_d = HOLD;
`ifdef UART_ARB_TIMEOUT_EN
            hold_cnt_d = '0;
`endif
          end
        end
      end
      GAP: begin
        if (gap_q == '0) state_d = IDLE;
        else gap_d = gap_q - GAP_W'(1);
      end
      default: state_d = IDLE;
    endcase
    if (frame_end) begin
      last_srv_d = owner_q;
      if (GAP_CYCLES == 0) begin
        state_d = IDLE;
      end else begin
        state_d = GAP;
        gap_d   = GAP_W'(GAP_CYCLES - 1);
      end
    end
  end

  always_comb begin
    grant_c = 2'b00;
    if (state_q == IDLE) grant_c = ready_c;
    else if (state_q != GAP) grant_c[owner_q] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      owner_q    <= 1'b0;
      last_srv_q <= 1'b1;
      data_q     <= '0;
      last_q     <= 1'b0;
      tx_start_q <= 1'b0;
      gap_q      <= '0;
`ifdef UART_ARB_TIMEOUT_EN
      hold_cnt_q <= '0;
      abort_q    <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      last_srv_q <= last_srv_d;
      data_q     <= data_d;
      last_q     <= last_d;
      tx_start_q <= tx_start_d;
      gap_q      <= gap_d;
`ifdef UART_ARB_TIMEOUT_EN
      hold_cnt_q <= hold_cnt_d;
      abort_q    <= abort_d;
`endif
    end
  end

  // Accepts are combinational so a byte loaded in cycle t starts in t+1; reset suppresses them.
  assign rq_ready_0 = ready_c[0] & ~rst;
  assign rq_ready_1 = ready_c[1] & ~rst;
  assign grant      = rst ? 2'b00 : grant_c;
  assign tx_start   = tx_start_q;
  assign tx_data    = data_q;
  assign busy       = (state_q != IDLE);
`ifdef UART_ARB_TIMEOUT_EN
  assign abort      = abort_q;
`else
  assign abort      = 1'b0;
`endif

endmodule
